up5bit_count_checker: RTL and testbench
=======================================

// Module: up5bit_count_checker
// PURPOSE
//  Downstream consumer of the up5bit_counter fabric output. Samples the 5-bit count each clk,
//  locks onto the sequence, predicts count+1 (mod 32) and flags mismatches, with error/check
//  tallies and a pass/done verdict. Used in place of bench-side model comparison, on-fabric or in sim.
// PARAMETERS
//  WIDTH       5   width of observed count bus
//  ERR_W       32  width of error and check tallies (saturating)
//  LOCK_N      2   consecutive correct increments needed to lock
//  RESYNC_N    3   consecutive mismatches in TRACK that force re-acquire
//  NUM_CHECKS  16  compares in TRACK before DONE
// PORTS
//  clk          in   1      rising-edge clock, shared with the counter
//  reset        in   1      asynchronous, active-high reset
//  start        in   1      one-cycle pulse: clear tallies, begin acquisition
//  cnt_in       in   WIDTH  count sampled from the counter under test
//  locked       out  1      high while in TRACK
//  mismatch     out  1      one-cycle pulse: cnt_in != expected in TRACK
//  err_count    out  ERR_W  total mismatches since start
//  chk_count    out  ERR_W  total compares since start
//  done         out  1      high in DONE
//  pass         out  1      done && err_count==0
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert inside block): state IDLE; all outputs 0; expected=0.
//  - Inputs registered once (cnt_q); every decision uses cnt_q -> 1-cycle latency cnt_in->mismatch.
//  - IDLE: start -> ACQUIRE, clear err_count, chk_count, lock/miss counters.
//  - ACQUIRE: expected <= cnt_q+1 (mod 2^WIDTH) each cycle; cnt_q==expected bumps lock_run, else
//    lock_run=0; lock_run reaches LOCK_N -> TRACK. No tallies change in ACQUIRE.
//  - TRACK: each cycle chk_count++; match -> expected<=expected+1, miss_run=0; mismatch ->
//    mismatch pulse, err_count++, expected<=cnt_q+1, miss_run++; miss_run==RESYNC_N -> ACQUIRE.
//    chk_count reaching NUM_CHECKS -> DONE (the NUM_CHECKS-th compare is counted first).
//  - DONE: hold tallies, done=1, pass per definition; start -> ACQUIRE with cleared tallies.
//  - Wrap: expected 31 -> 0 is a match, not an error. Tallies saturate at all-ones, never wrap.
//  - start in ACQUIRE/TRACK restarts acquisition (tallies cleared), same cycle rules as IDLE.
//  - Reset mid-TRACK: immediate return to IDLE, all outputs 0 regardless of clk.
//  - Mismatch and resync in same cycle: mismatch counted, then ACQUIRE.
// CONFIGURATION
//  UP5BIT_CHECK_CAPTURE_EN defined: adds outputs first_exp[WIDTH], first_obs[WIDTH],
//  first_idx[ERR_W] latching expected/observed/chk_count of the first mismatch after start;
//  cleared on reset/start. Undefined: ports and registers absent; all else identical.
// STRUCTURE
//  - Package up5bit_check_pkg: state enum {IDLE, ACQUIRE, TRACK, DONE}, default widths,
//    next_count() modulo-increment function.
//  - One sub-module: up5bit_sat_counter (ERR_W, clear, inc, value) used for both tallies.
//  - FSM, predictor and run counters in top module.
// TESTING
//  - Reset then start, cnt_in = 5,6,7,... -> locked 3 cycles after start; 16 checks -> done=1,
//    pass=1, err_count=0, chk_count=16.
//  - Locked stream 29,30,31,0,1 -> no mismatch pulse across wrap.
//  - Locked stream 10,11,20,21 -> one mismatch pulse at 20, err_count=1, stays locked, pass=0.
//  - Three consecutive bad values in TRACK -> err_count=3, locked drops, re-locks after 2 good.
//  - Assert reset mid-TRACK with clk stopped -> all outputs 0 immediately.
//  - With UP5BIT_CHECK_CAPTURE_EN: first error exp=12 obs=20 -> first_exp=12, first_obs=20,
//    unchanged by later errors.

Source files
------------

// File: rtl/up5bit_check_pkg.sv
// Shared types, default widths and the modulo-increment helper for the
// up5bit_count_checker slice.
package up5bit_check_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int DEF_WIDTH      = 5;
    localparam int DEF_ERR_W      = 32;
    localparam int DEF_LOCK_N     = 2;
    localparam int DEF_RESYNC_N   = 3;
    localparam int DEF_NUM_CHECKS = 16;

    // Increment modulo 2^w; the caller truncates the result to its own width.
    function automatic logic [31:0] next_count(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/up5bit_sat_counter.sv
// Saturating tally counter: synchronous clear has priority over increment,
// and the value sticks at all-ones instead of wrapping.
module up5bit_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && !(&value)) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/up5bit_count_checker.sv
// Locks onto an incrementing count stream, predicts the next value and tallies
// compares/mismatches. Optional first-mismatch capture under UP5BIT_CHECK_CAPTURE_EN.
module up5bit_count_checker
    import up5bit_check_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ERR_W      = DEF_ERR_W,
    parameter int LOCK_N     = DEF_LOCK_N,
    parameter int RESYNC_N   = DEF_RESYNC_N,
    parameter int NUM_CHECKS = DEF_NUM_CHECKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             locked,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] chk_count,
    output logic             done,
    output logic             pass,
`ifdef UP5BIT_CHECK_CAPTURE_EN
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_obs,
    output logic [ERR_W-1:0] first_idx,
`endif
    output logic [1:0]       state_dbg
);

    localparam int LRW = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
    localparam int MRW = (RESYNC_N > 1) ? $clog2(RESYNC_N) : 1;

    // Reset asserts asynchronously but is released only after two clean edges.
    logic [1:0] rst_sync;
    logic       rst_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign rst_i = rst_sync[1];

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] expected, expected_nxt;
    logic [LRW-1:0]   lock_run, lock_run_nxt;
    logic [MRW-1:0]   miss_run, miss_run_nxt;
    logic             clear_tallies;
    logic             chk_inc;
    logic             err_inc;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] exp_inc;

    assign cnt_inc = WIDTH'(next_count(32'(cnt_q), WIDTH));
    assign exp_inc = WIDTH'(next_count(32'(expected), WIDTH));

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt_q    <= '0;
            expected <= '0;
            lock_run <= '0;
            miss_run <= '0;
        end else begin
            state    <= state_nxt;
            cnt_q    <= cnt_in;
            expected <= expected_nxt;
            lock_run <= lock_run_nxt;
            miss_run <= miss_run_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        expected_nxt  = expected;
        lock_run_nxt  = lock_run;
        miss_run_nxt  = miss_run;
        clear_tallies = 1'b0;
        chk_inc       = 1'b0;
        err_inc       = 1'b0;
        mismatch      = 1'b0;
        if (start) begin
            state_nxt     = ACQUIRE;
            clear_tallies = 1'b1;
            lock_run_nxt  = '0;
            miss_run_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                end
                ACQUIRE: begin
                    expected_nxt = cnt_inc;
                    if (cnt_q == expected) begin
                        if (lock_run == LRW'(LOCK_N - 1)) begin
                            state_nxt    = TRACK;
                            lock_run_nxt = '0;
                            miss_run_nxt = '0;
                        end else begin
                            lock_run_nxt = lock_run + LRW'(1);
                        end
                    end else begin
                        lock_run_nxt = '0;
                    end
                end
                TRACK: begin
                    chk_inc = 1'b1;
                    if (cnt_q == expected) begin
                        expected_nxt = exp_inc;
                        miss_run_nxt = '0;
                    end else begin
                        mismatch     = 1'b1;
                        err_inc      = 1'b1;
                        expected_nxt = cnt_inc;
                        if (miss_run == MRW'(RESYNC_N - 1)) begin
                            state_nxt    = ACQUIRE;
                            miss_run_nxt = '0;
                            lock_run_nxt = '0;
                        end else begin
                            miss_run_nxt = miss_run + MRW'(1);
                        end
                    end
                    // Finishing the check budget wins over a simultaneous resync.
                    if (chk_count == ERR_W'(NUM_CHECKS - 1)) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    up5bit_sat_counter #(.W(ERR_W)) u_chk_tally (
        .clk   (clk),
        .reset (rst_i),
        .clear (clear_tallies),
        .inc   (chk_inc),
        .value (chk_count)
    );

    up5bit_sat_counter #(.W(ERR_W)) u_err_tally (
        .clk   (clk),
        .reset (rst_i),
        .clear (clear_tallies),
        .inc   (err_inc),
        .value (err_count)
    );

    assign locked    = (state == TRACK);
    assign done      = (state == DONE);
    assign pass      = done && (err_count == '0);
    assign state_dbg = state;

`ifdef UP5BIT_CHECK_CAPTURE_EN
    // first_idx records chk_count as it stands once the failing compare is counted.
    logic             captured;
    logic [ERR_W-1:0] chk_plus;

    assign chk_plus = (&chk_count) ? chk_count : chk_count + ERR_W'(1);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            captured  <= 1'b0;
            first_exp <= '0;
            first_obs <= '0;
            first_idx <= '0;
        end else if (clear_tallies) begin
            captured  <= 1'b0;
            first_exp <= '0;
            first_obs <= '0;
            first_idx <= '0;
        end else if (mismatch && !captured) begin
            captured  <= 1'b1;
            first_exp <= expected;
            first_obs <= cnt_q;
            first_idx <= chk_plus;
        end
    end
`endif

endmodule

// File: tb/tb_up5bit_count_checker.sv
// Bench for up5bit_count_checker: directed scenarios plus random streams compared
// every falling edge against a behavioural model (capture outputs when UP5BIT_CHECK_CAPTURE_EN).
module tb_up5bit_count_checker;

    localparam int LOCK_N     = 2;
    localparam int RESYNC_N   = 3;
    localparam int NUM_CHECKS = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clk_run = 1'b1;
    logic reset;
    logic start;
    logic [4:0] cnt_in;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    logic        locked, mismatch, done, pass;
    logic [31:0] err_count, chk_count;
    logic [1:0]  state_dbg;
`ifdef UP5BIT_CHECK_CAPTURE_EN
    logic [4:0]  first_exp, first_obs;
    logic [31:0] first_idx;
`endif

    up5bit_count_checker dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cnt_in    (cnt_in),
        .locked    (locked),
        .mismatch  (mismatch),
        .err_count (err_count),
        .chk_count (chk_count),
        .done      (done),
        .pass      (pass),
`ifdef UP5BIT_CHECK_CAPTURE_EN
        .first_exp (first_exp),
        .first_obs (first_obs),
        .first_idx (first_idx),
`endif
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int mm_seen  = 0;
    logic cmp_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_ACQ = 1, M_TRACK = 2, M_DONE = 3;
    int m_mode, m_ex, m_cq, m_run, m_miss, m_errs, m_chks, m_hold;
    bit m_cap_v;
    int m_cap_exp, m_cap_obs, m_cap_idx;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = M_IDLE; m_ex = 0; m_cq = 0; m_run = 0; m_miss = 0;
            m_errs = 0; m_chks = 0; m_hold = 2;
            m_cap_v = 0; m_cap_exp = 0; m_cap_obs = 0; m_cap_idx = 0;
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            if (start) begin
                m_mode = M_ACQ; m_errs = 0; m_chks = 0; m_run = 0; m_miss = 0;
                m_cap_v = 0; m_cap_exp = 0; m_cap_obs = 0; m_cap_idx = 0;
            end else if (m_mode == M_ACQ) begin
                if (m_cq == m_ex) m_run++; else m_run = 0;
                m_ex = (m_cq + 1) % 32;
                if (m_run >= LOCK_N) begin
                    m_mode = M_TRACK; m_run = 0; m_miss = 0;
                end
            end else if (m_mode == M_TRACK) begin
                m_chks++;
                if (m_cq == m_ex) begin
                    m_ex = (m_ex + 1) % 32;
                    m_miss = 0;
                end else begin
                    if (!m_cap_v) begin
                        m_cap_v = 1; m_cap_exp = m_ex; m_cap_obs = m_cq; m_cap_idx = m_chks;
                    end
                    m_errs++;
                    m_ex = (m_cq + 1) % 32;
                    m_miss++;
                    if (m_miss >= RESYNC_N) begin
                        m_mode = M_ACQ; m_run = 0; m_miss = 0;
                    end
                end
                if (m_chks >= NUM_CHECKS) m_mode = M_DONE;
            end
            m_cq = int'(cnt_in);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            if (mismatch === 1'b1) mm_seen++;
            check("locked",    64'(locked),    64'(m_mode == M_TRACK));
            check("mismatch",  64'(mismatch),  64'((m_mode == M_TRACK) && !start && (m_cq != m_ex)));
            check("err_count", 64'(err_count), 64'(m_errs));
            check("chk_count", 64'(chk_count), 64'(m_chks));
            check("done",      64'(done),      64'(m_mode == M_DONE));
            check("pass",      64'(pass),      64'((m_mode == M_DONE) && (m_errs == 0)));
`ifdef UP5BIT_CHECK_CAPTURE_EN
            check("first_exp", 64'(first_exp), 64'(m_cap_exp));
            check("first_obs", 64'(first_obs), 64'(m_cap_obs));
            check("first_idx", 64'(first_idx), 64'(m_cap_idx));
`endif
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic s, input logic [4:0] c);
        start  = s;
        cnt_in = c;
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"},   64'(locked),    64'd0);
        check({tag, "_mismatch"}, 64'(mismatch),  64'd0);
        check({tag, "_err"},      64'(err_count), 64'd0);
        check({tag, "_chk"},      64'(chk_count), 64'd0);
        check({tag, "_done"},     64'(done),      64'd0);
        check({tag, "_pass"},     64'(pass),      64'd0);
    endtask

    logic [4:0] cur;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        cnt_in = 5'd0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #2;
        reset  = 1'b0;
        cmp_on = 1'b1;
        repeat (3) cyc(1'b0, 5'd0);

        // Lock on 5,6,7,... then run the full check budget cleanly.
        cyc(1'b1, 5'd5);
        cyc(1'b0, 5'd6);
        cyc(1'b0, 5'd7);
        check("lock_not_yet", 64'(locked), 64'd0);
        cyc(1'b0, 5'd8);
        check("lock_3_cycles", 64'(locked), 64'd1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 5'(9 + i));
        check("chk_15", 64'(chk_count), 64'd15);
        check("not_done_15", 64'(done), 64'd0);
        cyc(1'b0, 5'd24);
        check("done_16", 64'(done), 64'd1);
        check("pass_16", 64'(pass), 64'd1);
        check("chk_16", 64'(chk_count), 64'd16);
        check("err_clean", 64'(err_count), 64'd0);

        // Wrap 31 -> 0 is not an error.
        cyc(1'b1, 5'd26);
        cyc(1'b0, 5'd27);
        cyc(1'b0, 5'd28);
        cyc(1'b0, 5'd29);
        check("wrap_locked", 64'(locked), 64'd1);
        mm_seen = 0;
        cyc(1'b0, 5'd30);
        cyc(1'b0, 5'd31);
        cyc(1'b0, 5'd0);
        cyc(1'b0, 5'd1);
        cyc(1'b0, 5'd2);
        check("wrap_no_pulse", 64'(mm_seen), 64'd0);
        check("wrap_err", 64'(err_count), 64'd0);
        check("wrap_still_locked", 64'(locked), 64'd1);

        // Single jump 11 -> 20: one pulse, stays locked, verdict fails.
        cyc(1'b1, 5'd7);
        cyc(1'b0, 5'd8);
        cyc(1'b0, 5'd9);
        cyc(1'b0, 5'd10);
        check("jump_locked", 64'(locked), 64'd1);
        cyc(1'b0, 5'd11);
        cyc(1'b0, 5'd20);
        check("jump_pulse", 64'(mismatch), 64'd1);
        cyc(1'b0, 5'd21);
        check("jump_err1", 64'(err_count), 64'd1);
        check("jump_pulse_once", 64'(mismatch), 64'd0);
        check("jump_stay_locked", 64'(locked), 64'd1);
`ifdef UP5BIT_CHECK_CAPTURE_EN
        check("cap_exp", 64'(first_exp), 64'd12);
        check("cap_obs", 64'(first_obs), 64'd20);
`endif
        cyc(1'b0, 5'd22);
        cyc(1'b0, 5'd30);
        cur = 5'd30;
        for (int i = 0; i < 20; i++) begin
            cur = cur + 5'd1;
            cyc(1'b0, cur);
        end
        check("jump_done", 64'(done), 64'd1);
        check("jump_pass0", 64'(pass), 64'd0);
        check("jump_err2", 64'(err_count), 64'd2);
`ifdef UP5BIT_CHECK_CAPTURE_EN
        check("cap_exp_held", 64'(first_exp), 64'd12);
        check("cap_obs_held", 64'(first_obs), 64'd20);
`endif

        // Three consecutive misses force re-acquire, then re-lock after two good.
        cyc(1'b1, 5'd0);
        cyc(1'b0, 5'd1);
        cyc(1'b0, 5'd2);
        cyc(1'b0, 5'd3);
        cyc(1'b0, 5'd4);
        cyc(1'b0, 5'd15);
        cyc(1'b0, 5'd9);
        cyc(1'b0, 5'd25);
        check("resync_pre_locked", 64'(locked), 64'd1);
        cyc(1'b0, 5'd8);
        check("resync_err3", 64'(err_count), 64'd3);
        check("resync_dropped", 64'(locked), 64'd0);
        cyc(1'b0, 5'd9);
        cyc(1'b0, 5'd10);
        check("resync_one_good", 64'(locked), 64'd0);
        cyc(1'b0, 5'd11);
        check("resync_relocked", 64'(locked), 64'd1);
        cyc(1'b0, 5'd12);

        // Reset while tracking with the clock stopped.
        @(negedge clk);
        clk_run = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        #2;
        reset = 1'b0;
        #2;
        clk_run = 1'b1;
        @(posedge clk);
        #2;
        repeat (3) cyc(1'b0, 5'd0);

        // Random streams: mostly counting, occasional jumps, starts and resets.
        cur = 5'($urandom_range(0, 31));
        for (int i = 0; i < 3000; i++) begin
            logic s;
            s = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) cur = 5'($urandom_range(0, 31));
            else cur = cur + 5'd1;
            cyc(s, cur);
            if ($urandom_range(0, 499) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
